ram_rr_arbiter: RTL

//  Shares one asynchronous-read, level-write single-port RAM (1024x8) between two requesters, A and B.

---
 rtl/ram_rr_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ram_rr_arbiter.sv
// rtl/ram_rr_arbiter.sv - two-requester round-robin arbiter sequencing a single-port async-read RAM
module ram_rr_arbiter #(
    parameter int addr_size = 10,
    parameter int word_size = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    // requester A
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic                 a_wr_i,
    input  logic [addr_size-1:0] a_addr_i,
    input  logic [word_size-1:0] a_wdata_i,
    output logic                 a_rvalid_o,
    output logic [word_size-1:0] a_rdata_o,
    // requester B
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic                 b_wr_i,
    input  logic [addr_size-1:0] b_addr_i,
    input  logic [word_size-1:0] b_wdata_i,
    output logic                 b_rvalid_o,
    output logic [word_size-1:0] b_rdata_o,
    // RAM macro
    output logic                 mem_cs_o,
    output logic                 mem_wr_o,
    output logic [addr_size-1:0] mem_addr_o,
    output logic [word_size-1:0] mem_din_o,
    input  logic [word_size-1:0] mem_dout_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e               state_q;
    logic                 last_b_q;   // 1: B was granted last, so A wins a tie
    logic                 win_b_q;    // owner of the transaction in flight
    logic                 wr_q;
    logic                 mem_cs_q;
    logic                 mem_wr_q;
    logic [addr_size-1:0] mem_addr_q;
    logic [word_size-1:0] mem_din_q;
    logic                 a_rvalid_q;
    logic                 b_rvalid_q;
    logic [word_size-1:0] a_rdata_q;
    logic [word_size-1:0] b_rdata_q;
    logic                 pick_a;
    logic                 pick_b;

    // Grant decision: only in IDLE, tie broken against the last winner
    always_comb begin
        pick_a = 1'b0;
        pick_b = 1'b0;
        if (state_q == IDLE) begin
            pick_a = a_valid_i && (!b_valid_i || last_b_q);
            pick_b = b_valid_i && (!a_valid_i || !last_b_q);
        end
    end

    // Ready is the same-cycle grant; held low while reset is asserted
    assign a_ready_o = pick_a && rst_n_i;
    assign b_ready_o = pick_b && rst_n_i;

    assign mem_cs_o   = mem_cs_q;
    assign mem_wr_o   = mem_wr_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_din_o  = mem_din_q;
    assign a_rvalid_o = a_rvalid_q;
    assign b_rvalid_o = b_rvalid_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;

    // Transaction sequencer: address/data settle a cycle before and after the write strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            win_b_q    <= 1'b0;
            wr_q       <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_a || pick_b) begin
                        state_q    <= SETUP;
                        win_b_q    <= pick_b;
                        last_b_q   <= pick_b;
                        wr_q       <= pick_b ? b_wr_i    : a_wr_i;
                        mem_addr_q <= pick_b ? b_addr_i  : a_addr_i;
                        mem_din_q  <= pick_b ? b_wdata_i : a_wdata_i;
                        mem_cs_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q  <= STROBE;
                    mem_wr_q <= wr_q;
                end
                STROBE: begin
                    state_q  <= DONE;
                    mem_cs_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    if (!wr_q) begin
                        if (win_b_q) begin
                            b_rdata_q  <= mem_dout_i;
                            b_rvalid_q <= 1'b1;
                        end else begin
                            a_rdata_q  <= mem_dout_i;
                            a_rvalid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    a_rvalid_q <= 1'b0;
                    b_rvalid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
